// File: rtl/pipeline_trace_buffer_pkg.sv
// Shared definitions for the pipeline trace buffer.
//   - default geometry (channels, payload width, depth, timestamp width)
//   - FSM state encoding and trigger-mode encoding
//   - entry_w(): width of one stored entry {timestamp, ch_v, ch_data}
package pipeline_trace_buffer_pkg;

  localparam int CH_DEF    = 4;
  localparam int W_DEF     = 16;
  localparam int DEPTH_DEF = 32;
  localparam int TS_W_DEF  = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_POST = 3'd2,
    ST_DONE = 3'd3,
    ST_READ = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    TRIG_EXT   = 2'b00,  // external trig_i
    TRIG_MATCH = 2'b01,  // masked compare on channel 0
    TRIG_FALL  = 2'b10,  // any channel valid falling edge
    TRIG_NOW   = 2'b11   // first recording cycle
  } trig_mode_e;

  function automatic int entry_w(input int ch, input int w, input int ts_w);
    return ts_w + ch + ch * w;
  endfunction

endpackage

// File: rtl/pipeline_trace_buffer_if.sv
// Read-out port of the trace buffer (valid/ready stream of entries).
//   rd_valid_o : producer holds an entry on rd_data_o
//   rd_data_o  : {timestamp, ch_v, ch_data}
//   rd_last_o  : entry is the newest in the captured window
//   rd_ready_i : consumer accepts rd_data_o this cycle
// master = trace buffer side, slave = consumer side.
interface pipeline_trace_buffer_if
  import pipeline_trace_buffer_pkg::*;
#(
  parameter int DATA_W = entry_w(CH_DEF, W_DEF, TS_W_DEF)
) ();

  logic              rd_valid_o;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_last_o;
  logic              rd_ready_i;

  modport master (
    output rd_valid_o,
    output rd_data_o,
    output rd_last_o,
    input  rd_ready_i
  );

  modport slave (
    input  rd_valid_o,
    input  rd_data_o,
    input  rd_last_o,
    output rd_ready_i
  );

endinterface

// File: rtl/pipeline_trace_buffer_ram.sv
// Trace storage: DEPTH x DATA_W, one synchronous write port and one
// asynchronous (combinational) read port.
//   clk     : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data, combinational from i_raddr
module pipeline_trace_buffer_ram #(
  parameter  int DEPTH  = 32,
  parameter  int DATA_W = 84,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset; only entries written in the current
  // capture are ever read, so clearing it would buy nothing and would stop
  // it mapping onto RAM. Non-blocking assignment models the clocked write.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pipeline_trace_buffer.sv
// Per-cycle pipeline trace recorder.
// Snapshots CH channels every cycle into a circular buffer while recording,
// stops a programmable number of entries after a trigger, then streams the
// captured window out oldest-first.
//   clk, rst    : clock, asynchronous active-low reset
//   arm_i       : pulse, clear and start recording (PRE)
//   abort_i     : pulse, back to IDLE, capture discarded (wins over arm_i)
//   trig_mode_i : 00 trig_i, 01 ch0 masked match, 10 valid fall, 11 immediate
//   trig_i      : external trigger
//   match_val_i : ch0 compare value, match_msk_i: 1 = bit compared
//   post_cnt_i  : entries recorded after the trigger entry (sampled at arm)
//   ch_v_i      : per-channel valid, ch_data_i: payloads, ch0 in LSBs
//   rd          : read-out stream (master side)
//   trig_pos_o  : read index of the trigger entry, valid in DONE/READ
//   state_o     : FSM state
module pipeline_trace_buffer
  import pipeline_trace_buffer_pkg::*;
#(
  parameter  int CH      = CH_DEF,
  parameter  int W       = W_DEF,
  parameter  int DEPTH   = DEPTH_DEF,
  parameter  int TS_W    = TS_W_DEF,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int ENTRY_W = entry_w(CH, W, TS_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm_i,
  input  logic                 abort_i,
  input  logic [1:0]           trig_mode_i,
  input  logic                 trig_i,
  input  logic [W-1:0]         match_val_i,
  input  logic [W-1:0]         match_msk_i,
  input  logic [PTR_W-1:0]     post_cnt_i,
  input  logic [CH-1:0]        ch_v_i,
  input  logic [CH*W-1:0]      ch_data_i,
  pipeline_trace_buffer_if.master rd,
  output logic [PTR_W-1:0]     trig_pos_o,
  output logic [2:0]           state_o
);

  state_e               r_state, w_state_nxt;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W:0]       r_fill;
  logic [TS_W-1:0]      r_ts;
  logic                 r_first;
  logic [CH-1:0]        r_prev_v;
  logic [PTR_W-1:0]     r_post_left;
  logic [PTR_W-1:0]     r_trig_addr;
  logic [PTR_W:0]       r_rd_cnt;
  logic                 r_rd_valid;
  logic                 r_rd_last;
  logic [ENTRY_W-1:0]   r_rd_data;

  logic                 w_wr_en;
  logic                 w_full;
  logic [PTR_W-1:0]     w_oldest;
  logic [PTR_W-1:0]     w_rd_addr;
  logic [ENTRY_W-1:0]   w_ram_rdata;
  logic                 w_match;
  logic                 w_fall;
  logic                 w_trig;
  logic                 w_rd_fire;
  logic                 w_rd_load;

  // Entries written during an arm/abort cycle are discarded by the clear.
  assign w_wr_en   = (r_state == ST_PRE || r_state == ST_POST) && !arm_i && !abort_i;
  assign w_full    = (r_fill == (PTR_W+1)'(DEPTH));
  assign w_oldest  = w_full ? r_wr_ptr : '0;
  assign w_rd_addr = w_oldest + r_rd_cnt[PTR_W-1:0];

  assign w_match = ch_v_i[0] && (((ch_data_i[W-1:0] ^ match_val_i) & match_msk_i) == '0);
  // r_prev_v is stale on the first recording cycle, so no fall can be seen then.
  assign w_fall  = !r_first && ((r_prev_v & ~ch_v_i) != '0);

  assign w_rd_fire = r_rd_valid && rd.rd_ready_i;
  assign w_rd_load = (r_state == ST_READ) && (r_rd_cnt < r_fill) && (!r_rd_valid || rd.rd_ready_i);

  // NOTE: every combinational output gets a default before any branch, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_trig = 1'b0;
    case (trig_mode_e'(trig_mode_i))
      TRIG_EXT:   w_trig = trig_i;
      TRIG_MATCH: w_trig = w_match;
      TRIG_FALL:  w_trig = w_fall;
      TRIG_NOW:   w_trig = r_first;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (arm_i) w_state_nxt = ST_PRE;
      ST_PRE:  if (w_trig) w_state_nxt = (r_post_left == '0) ? ST_DONE : ST_POST;
      ST_POST: if (r_post_left == PTR_W'(1)) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_READ;
      ST_READ: if (w_rd_fire && r_rd_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (arm_i)   w_state_nxt = ST_PRE;
    if (abort_i) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_fill      <= '0;
      r_ts        <= '0;
      r_first     <= 1'b1;
      r_prev_v    <= '0;
      r_post_left <= '0;
      r_trig_addr <= '0;
      r_rd_cnt    <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_rd_data   <= '0;
    end else if (abort_i) begin
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end else if (arm_i) begin
      r_wr_ptr    <= '0;
      r_fill      <= '0;
      r_ts        <= '0;
      r_first     <= 1'b1;
      // The port width already bounds post_cnt_i to DEPTH-1, which keeps
      // the trigger entry inside the window.
      r_post_left <= post_cnt_i;
      r_rd_cnt    <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (!w_full) r_fill <= r_fill + (PTR_W+1)'(1);
        r_ts     <= r_ts + TS_W'(1);
        r_prev_v <= ch_v_i;
        r_first  <= 1'b0;
        if (r_state == ST_PRE && w_trig) r_trig_addr <= r_wr_ptr;
        if (r_state == ST_POST) r_post_left <= r_post_left - PTR_W'(1);
      end
      if (w_rd_load) begin
        r_rd_data  <= w_ram_rdata;
        r_rd_valid <= 1'b1;
        r_rd_last  <= (r_rd_cnt == r_fill - (PTR_W+1)'(1));
        r_rd_cnt   <= r_rd_cnt + (PTR_W+1)'(1);
      end else if (w_rd_fire) begin
        r_rd_valid <= 1'b0;
        r_rd_last  <= 1'b0;
      end
    end
  end

  pipeline_trace_buffer_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr),
    .i_wdata ({r_ts, ch_v_i, ch_data_i}),
    .i_raddr (w_rd_addr),
    .o_rdata (w_ram_rdata)
  );

  assign rd.rd_valid_o = r_rd_valid;
  assign rd.rd_data_o  = r_rd_data;
  assign rd.rd_last_o  = r_rd_last;

  // Modular subtraction gives the trigger's distance from the oldest entry.
  assign trig_pos_o = (r_state == ST_DONE || r_state == ST_READ) ? (r_trig_addr - w_oldest) : '0;
  assign state_o    = r_state;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
module tb_pipeline_trace_buffer;
  import pipeline_trace_buffer_pkg::*;

  localparam int CH      = 4;
  localparam int W       = 16;
  localparam int DEPTH   = 32;
  localparam int TS_W    = 16;
  localparam int PTR_W   = 5;
  localparam int ENTRY_W = TS_W + CH + CH * W;
  localparam int MAXC    = 128;

  logic               clk;
  logic               rst;
  logic               arm_i;
  logic               abort_i;
  logic [1:0]         trig_mode_i;
  logic               trig_i;
  logic [W-1:0]       match_val_i;
  logic [W-1:0]       match_msk_i;
  logic [PTR_W-1:0]   post_cnt_i;
  logic [CH-1:0]      ch_v_i;
  logic [CH*W-1:0]    ch_data_i;
  logic [PTR_W-1:0]   trig_pos_o;
  logic [2:0]         state_o;

  pipeline_trace_buffer_if #(.DATA_W(ENTRY_W)) rd_if ();

  pipeline_trace_buffer #(
    .CH(CH), .W(W), .DEPTH(DEPTH), .TS_W(TS_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .arm_i       (arm_i),
    .abort_i     (abort_i),
    .trig_mode_i (trig_mode_i),
    .trig_i      (trig_i),
    .match_val_i (match_val_i),
    .match_msk_i (match_msk_i),
    .post_cnt_i  (post_cnt_i),
    .ch_v_i      (ch_v_i),
    .ch_data_i   (ch_data_i),
    .rd          (rd_if),
    .trig_pos_o  (trig_pos_o),
    .state_o     (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [ENTRY_W-1:0] data;
    logic               last;
  } exp_t;

  exp_t sb[$];

  // Stimulus table for one capture: cycle k is the k-th recording cycle.
  logic [CH-1:0]   sv [MAXC];
  logic [CH*W-1:0] sd [MAXC];
  logic            st [MAXC];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic gen_stim();
    for (int k = 0; k < MAXC; k++) begin
      sv[k] = CH'($urandom);
      sd[k] = {$urandom(), $urandom()};
      st[k] = ($urandom_range(0, 15) == 0);
    end
  endtask

  function automatic bit trig_hit(input logic [1:0] mode, input int k,
                                  input logic [W-1:0] val, input logic [W-1:0] msk);
    bit hit;
    hit = 1'b0;
    case (mode)
      2'b00: hit = st[k];
      2'b01: hit = sv[k][0] && (((sd[k][W-1:0] ^ val) & msk) == '0);
      2'b10: if (k > 0) hit = ((sv[k-1] & ~sv[k]) != '0);
      default: hit = (k == 0);
    endcase
    return hit;
  endfunction

  function automatic logic ready_at(input int pat, input int c);
    if (pat == 0) return 1'b1;
    if (pat == 1) return ((c % 2) == 0);
    return 1'($urandom_range(0, 1));
  endfunction

  // Reference: find the trigger cycle in the table, the capture stops
  // post entries later, and the window is the newest DEPTH entries.
  task automatic run_capture(input logic [1:0] mode, input int post,
                             input logic [W-1:0] val, input logic [W-1:0] msk,
                             input int pat, input bit full);
    int t, pc, n, s, tp, k, cyc;
    t = -1;
    for (int i = 0; i < MAXC && t < 0; i++)
      if (trig_hit(mode, i, val, msk)) t = i;
    if (t < 0) begin
      $display("FAIL stimulus: table holds no trigger");
      $fatal(1);
    end
    pc = (post > DEPTH - 1) ? DEPTH - 1 : post;
    n  = t + pc + 1;
    s  = (n > DEPTH) ? n - DEPTH : 0;
    tp = t - s;
    for (int i = s; i < n; i++)
      sb.push_back('{data: {TS_W'(i), sv[i], sd[i]}, last: (i == n - 1)});

    trig_mode_i = mode;
    match_val_i = val;
    match_msk_i = msk;
    post_cnt_i  = PTR_W'(post);
    ch_v_i      = '1;
    arm_i       = 1'b1;
    @(posedge clk); #1;
    arm_i = 1'b0;
    check("state_pre", state_o, ST_PRE);

    k = 0;
    while (state_o != ST_DONE && k < MAXC) begin
      ch_v_i    = sv[k];
      ch_data_i = sd[k];
      trig_i    = st[k];
      @(posedge clk); #1;
      k++;
    end
    ch_v_i    = CH'($urandom);
    ch_data_i = {$urandom(), $urandom()};
    trig_i    = 1'b1;
    check("cycles_to_done", k, n);
    if (state_o != ST_DONE) begin
      sb.delete();
      return;
    end
    check("trig_pos_done", trig_pos_o, tp);

    rd_if.rd_ready_i = ready_at(pat, 0);
    @(posedge clk); #1;
    check("state_read", state_o, ST_READ);
    check("first_read_cycle_invalid", rd_if.rd_valid_o, 1'b0);
    check("trig_pos_read", trig_pos_o, tp);

    if (full) begin
      cyc = 0;
      while (!(state_o == ST_IDLE && sb.size() == 0) && cyc < 400) begin
        @(posedge clk); #1;
        cyc++;
        rd_if.rd_ready_i = ready_at(pat, cyc);
      end
      check("read_done", {state_o == ST_IDLE, sb.size() == 0}, 2'b11);
      check("valid_after_last", rd_if.rd_valid_o, 1'b0);
      sb.delete();
    end else begin
      repeat (3) begin
        @(posedge clk); #1;
      end
      rd_if.rd_ready_i = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("valid_before_rst", rd_if.rd_valid_o, 1'b1);
      rst = 1'b0;
      #1;
      check("rst_valid", rd_if.rd_valid_o, 1'b0);
      check("rst_last", rd_if.rd_last_o, 1'b0);
      check("rst_state", state_o, ST_IDLE);
      check("rst_trig_pos", trig_pos_o, 0);
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b1;
    end
  endtask

  // Monitor: pops the scoreboard on every accepted entry and checks that a
  // stalled entry is held unchanged.
  initial begin : monitor
    logic               pv, pr;
    logic [ENTRY_W-1:0] pd;
    exp_t               e;
    pv = 1'b0; pr = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      if (rst && rd_if.rd_valid_o) begin
        if (pv && !pr) check("hold_data", rd_if.rd_data_o, pd);
        if (rd_if.rd_ready_i) begin
          if (sb.size() == 0) begin
            check("unexpected_entry", rd_if.rd_valid_o, 1'b0);
          end else begin
            e = sb.pop_front();
            check("rd_data", rd_if.rd_data_o, e.data);
            check("rd_last", rd_if.rd_last_o, e.last);
          end
        end
      end
      pv = rst && rd_if.rd_valid_o;
      pr = rd_if.rd_ready_i;
      pd = rd_if.rd_data_o;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [1:0]   m;
    int           c, p;
    logic [W-1:0] val, msk;

    arm_i = 1'b0; abort_i = 1'b0; trig_mode_i = '0; trig_i = 1'b0;
    match_val_i = '0; match_msk_i = '0; post_cnt_i = '0;
    ch_v_i = '0; ch_data_i = '0; rd_if.rd_ready_i = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", state_o, ST_IDLE);
    check("reset_valid", rd_if.rd_valid_o, 1'b0);
    check("reset_last", rd_if.rd_last_o, 1'b0);
    check("reset_data", rd_if.rd_data_o, '0);
    check("reset_trig_pos", trig_pos_o, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", state_o, ST_IDLE);

    // Immediate trigger, ch0 = cycle number, 4 entries.
    gen_stim();
    for (int k = 0; k < MAXC; k++) sd[k][W-1:0] = W'(k);
    run_capture(2'b11, 3, '0, '0, 0, 1'b1);

    // External trigger at cycle 40, post 8: wrapped window ts 17..48.
    gen_stim();
    for (int k = 0; k < MAXC; k++) st[k] = 1'b0;
    st[40] = 1'b1;
    run_capture(2'b00, 8, '0, '0, 0, 1'b1);

    // ch0 match: masked value with valid low at 3 (ignored), valid at 7.
    gen_stim();
    for (int k = 0; k < MAXC; k++)
      if (sd[k][7:0] == 8'hA5) sd[k][7:0] = 8'h5A;
    sd[3][W-1:0] = 16'h12A5; sv[3][0] = 1'b0;
    sd[7][W-1:0] = 16'h12A5; sv[7][0] = 1'b1;
    run_capture(2'b01, 4, 16'h00A5, 16'h00FF, 1, 1'b1);

    // Maximum post count: trigger entry ends up oldest of 32.
    gen_stim();
    run_capture(2'b11, 31, '0, '0, 1, 1'b1);
    gen_stim();
    for (int k = 0; k < MAXC; k++) st[k] = 1'b0;
    st[50] = 1'b1;
    run_capture(2'b00, 31, '0, '0, 1, 1'b1);

    // Randomised captures across all modes with random back-pressure.
    for (int r = 0; r < 8; r++) begin
      m   = 2'(r % 4);
      p   = $urandom_range(0, 31);
      c   = $urandom_range(1, 90);
      val = W'($urandom);
      msk = W'($urandom);
      gen_stim();
      case (m)
        2'b00: st[c] = 1'b1;
        2'b01: begin
          sd[c][W-1:0] = (val & msk) | (W'($urandom) & ~msk);
          sv[c][0] = 1'b1;
        end
        2'b10: begin
          sv[0] = '0;
          sv[c-1][0] = 1'b1;
          sv[c] = '0;
        end
        default: ;
      endcase
      run_capture(m, p, val, msk, 2, 1'b1);
    end

    // Abort while in POST.
    gen_stim();
    for (int k = 0; k < MAXC; k++) st[k] = 1'b0;
    st[5] = 1'b1;
    trig_mode_i = 2'b00;
    post_cnt_i  = PTR_W'(10);
    arm_i = 1'b1;
    @(posedge clk); #1;
    arm_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ch_v_i = sv[k]; ch_data_i = sd[k]; trig_i = st[k];
      @(posedge clk); #1;
    end
    check("abort_from_post", state_o, ST_POST);
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    check("abort_idle", state_o, ST_IDLE);
    check("abort_valid", rd_if.rd_valid_o, 1'b0);

    // Reset asserted in the middle of a read-out.
    gen_stim();
    run_capture(2'b11, 5, '0, '0, 0, 1'b0);
    check("idle_after_mid_read_rst", state_o, ST_IDLE);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
